// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeat_n+1 times with idle gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_tx #(
    parameter int              PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = 4'b1010,
    parameter int              CNT_W     = 4,
    parameter int              GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SEND, PAR, GAP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, GAP, DONE} state_t;
`endif

    state_t           state, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] repn_q, repn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_dec;
    logic [3:0]       gap_q, gap_d;
    logic             ready_d, busy_d, ser_out_d, ser_valid_d, frame_start_d, done_d;
    logic             rep_end, load_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= PAT_RESET;
            repn_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            pat_q       <= pat_d;
            repn_q      <= repn_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            ready       <= ready_d;
            busy        <= busy_d;
            ser_out     <= ser_out_d;
            ser_valid   <= ser_valid_d;
            frame_start <= frame_start_d;
            done        <= done_d;
        end
    end

    // Outputs are computed from the next state so they appear registered in the same cycle as that state.
    always_comb begin
        state_d       = state;
        pat_d         = pat_q;
        repn_d        = repn_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        idx_dec       = idx_q - 1'b1;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        rep_end       = 1'b0;
        load_msb      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pat_d         = pattern;
                    repn_d        = repeat_n;
                    cnt_d         = '0;
                    state_d       = SEND;
                    idx_d         = IDX_MSB;
                    ser_out_d     = pattern[PAT_W-1];
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            SEND: begin
                if (idx_q != '0) begin
                    idx_d       = idx_dec;
                    ser_out_d   = pat_q[idx_dec];
                    ser_valid_d = 1'b1;
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d     = PAR;
                    ser_out_d   = ^pat_q;
                    ser_valid_d = 1'b1;
`else
                    rep_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            PAR: rep_end = 1'b1;
`endif
            GAP: begin
                if (int'(gap_q) + 1 >= GAP_LEN) begin
                    load_msb = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rep_end) begin
            if (cnt_q < repn_q) begin
                cnt_d = cnt_q + 1'b1;
                if (GAP_LEN > 0) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else begin
                    load_msb = 1'b1;
                end
            end else begin
                state_d = DONE;
            end
        end

        if (load_msb) begin
            state_d       = SEND;
            idx_d         = IDX_MSB;
            ser_out_d     = pat_q[PAT_W-1];
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end

        // Abort only cuts an active transfer; the latched pattern is kept.
        if (abort && state != IDLE && state != DONE) begin
            state_d       = IDLE;
            cnt_d         = '0;
            idx_d         = '0;
            gap_d         = '0;
            ser_out_d     = 1'b0;
            ser_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx: two instances (GAP_LEN=1 and GAP_LEN=0) share stimulus and are
// compared cycle by cycle against per-transfer expected output streams built from the transfer rules.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam logic [5:0] IDLE_V = 6'b100000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] repeat_n = '0;

    logic ready1, busy1, ser1, val1, fs1, done1;
    logic ready0, busy0, ser0, val0, fs0, done0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(4), .PAT_RESET(4'b1010), .CNT_W(4), .GAP_LEN(1)) dut_g1 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeat_n(repeat_n),
        .abort(abort), .ready(ready1), .busy(busy1), .ser_out(ser1), .ser_valid(val1),
        .frame_start(fs1), .done(done1)
    );

    seq_pattern_tx #(.PAT_W(4), .PAT_RESET(4'b1010), .CNT_W(4), .GAP_LEN(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeat_n(repeat_n),
        .abort(abort), .ready(ready0), .busy(busy0), .ser_out(ser0), .ser_valid(val0),
        .frame_start(fs0), .done(done0)
    );

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (ready,busy,ser_out,ser_valid,frame_start,done)", tag, got, exp);
        end
    endtask

    // Expected outputs from the cycle after acceptance through the DONE cycle.
    function automatic void build(input logic [3:0] p, input int rn, input int gap, output logic [5:0] q[$]);
        q = {};
        for (int k = 0; k <= rn; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                q.push_back({1'b0, 1'b1, p[b], 1'b1, (b == PAT_W - 1), 1'b0});
            if (P == 1)
                q.push_back({2'b01, ^p, 3'b100});
            if (k < rn)
                for (int g = 0; g < gap; g++) q.push_back(6'b010000);
        end
        q.push_back(6'b010001);
    endfunction

    function automatic logic [5:0] exp_at(input logic [5:0] q[$], input int i);
        return (i < q.size()) ? q[i] : IDLE_V;
    endfunction

    // kind: 0 = normal, 1 = abort at cycle kill_at, 2 = reset at cycle kill_at
    task automatic run_xfer(input logic [3:0] p, input int rn, input int kill_at, input int kind);
        logic [5:0] q1[$];
        logic [5:0] q0[$];
        logic [5:0] e1, e0;
        int len;
        build(p, rn, 1, q1);
        build(p, rn, 0, q0);
        start    = 1'b1;
        pattern  = p;
        repeat_n = rn[3:0];
        len = (kind != 0) ? kill_at + 2 : q1.size() + 1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            e1 = (kind != 0 && i > kill_at) ? IDLE_V : exp_at(q1, i);
            e0 = (kind != 0 && i > kill_at) ? IDLE_V : exp_at(q0, i);
            check($sformatf("g1 p=%b rn=%0d k=%0d t%0d", p, rn, kind, i), {ready1, busy1, ser1, val1, fs1, done1}, e1);
            check($sformatf("g0 p=%b rn=%0d k=%0d t%0d", p, rn, kind, i), {ready0, busy0, ser0, val0, fs0, done0}, e0);
            abort = 1'b0;
            reset = 1'b0;
            if (kind != 0 && i == kill_at) begin
                if (kind == 1) abort = 1'b1;
                else reset = 1'b1;
            end else if ((e1[5] || e1[0]) && (e0[5] || e0[0])) begin
                abort = ($urandom % 3 == 0);
            end
            start    = (!e1[5] && !e0[5] && i != len - 1) ? 1'($urandom % 2) : 1'b0;
            pattern  = 4'($urandom);
            repeat_n = 4'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int rn, kind, at;
        repeat (3) @(negedge clk);
        check("reset g1", {ready1, busy1, ser1, val1, fs1, done1}, IDLE_V);
        check("reset g0", {ready0, busy0, ser0, val0, fs0, done0}, IDLE_V);
        reset = 1'b0;

        run_xfer(4'b1010, 0, 0, 0);
        run_xfer(4'b1100, 2, 0, 0);
        run_xfer(4'b1010, 1, 0, 0);
        run_xfer(4'b1011, 0, 0, 0);
        run_xfer(4'b1100, 2, 7 + P, 1);
        run_xfer(4'b0110, 1, PAT_W + P, 2);
        run_xfer(4'b1001, 15, 0, 0);
        run_xfer(4'b0001, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            rn   = $urandom_range(0, 3);
            kind = ($urandom % 4 == 0) ? 1 + int'($urandom % 2) : 0;
            at   = $urandom_range(0, (rn + 1) * (PAT_W + P) - 1);
            run_xfer(4'($urandom), rn, at, kind);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
